// File: rtl/header_stripper.sv
// Strips the leading HEADER_SIZE/DATA_WIDTH beats of each packet into o_header_data; payload passes through.
// Header beats are always accepted (ready=1); payload is zero-latency combinational and follows i_out_ready.
module header_stripper #(
  parameter int DATA_WIDTH  = 128,
  parameter int HEADER_SIZE = 256,
  parameter int EMPTY_WIDTH = $clog2(DATA_WIDTH/8)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_in_sop,
  input  logic                   i_in_eop,
  input  logic [DATA_WIDTH-1:0]  i_in_data,
  input  logic [EMPTY_WIDTH-1:0] i_in_empty,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_out_sop,
  output logic                   o_out_eop,
  output logic [DATA_WIDTH-1:0]  o_out_data,
  output logic [EMPTY_WIDTH-1:0] o_out_empty,
  output logic [HEADER_SIZE-1:0] o_header_data,
  output logic                   o_header_valid,
  output logic                   o_header_err
);

  localparam int N     = HEADER_SIZE / DATA_WIDTH;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE_ST   = 2'd0,
    HEADER_ST = 2'd1,
    DATA_ST   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_hdr_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_idx;
  logic [HEADER_SIZE-1:0] r_hdr_shd;
  logic [HEADER_SIZE-1:0] w_shd_nxt;
  logic [HEADER_SIZE-1:0] r_header_data;
  logic                   r_header_valid;
  logic                   r_header_err;
  logic                   r_first_pl;
  logic                   w_store;
  logic                   w_done;
  logic                   w_err;
  logic                   w_in_ready;
  logic                   w_beat;

  assign w_beat = i_in_valid & w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_ST;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_hdr_cnt;
    w_store     = 1'b0;
    w_idx       = '0;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE_ST: begin
        if (w_beat && i_in_sop) begin
          if (i_in_eop) begin
            w_err = 1'b1;
          end else begin
            w_store = 1'b1;
            if (N == 1) begin
              w_state_nxt = DATA_ST;
              w_done      = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = HEADER_ST;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
      end
      HEADER_ST: begin
        if (w_beat) begin
          if (i_in_sop && !i_in_eop) begin
            // A fresh sop mid-header abandons the old header and starts over.
            w_store   = 1'b1;
            w_cnt_nxt = CNT_W'(1);
            w_err     = 1'b1;
          end else if (i_in_eop) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE_ST;
            w_cnt_nxt   = '0;
          end else begin
            w_store = 1'b1;
            w_idx   = r_hdr_cnt;
            if (r_hdr_cnt == CNT_W'(N - 1)) begin
              w_state_nxt = DATA_ST;
              w_done      = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_hdr_cnt + CNT_W'(1);
            end
          end
        end
      end
      DATA_ST: begin
        if (w_beat && i_in_eop) begin
          w_state_nxt = IDLE_ST;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE_ST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b1;
    o_out_valid = 1'b0;
    o_out_sop   = 1'b0;
    o_out_eop   = 1'b0;
    o_out_data  = '0;
    o_out_empty = '0;
    if (r_state == DATA_ST) begin
      w_in_ready  = i_out_ready;
      o_out_valid = i_in_valid;
      o_out_sop   = r_first_pl;
      o_out_eop   = i_in_eop;
      o_out_data  = i_in_data;
      o_out_empty = i_in_eop ? i_in_empty : '0;
    end
  end

  // First received beat lands in the MSBs of the shadow.
  always_comb begin
    w_shd_nxt = r_hdr_shd;
    if (w_store) begin
      for (int k = 0; k < N; k++) begin
        if (w_idx == CNT_W'(k)) begin
          w_shd_nxt[HEADER_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH] = i_in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hdr_cnt      <= '0;
      r_hdr_shd      <= '0;
      r_header_data  <= '0;
      r_header_valid <= 1'b0;
      r_header_err   <= 1'b0;
      r_first_pl     <= 1'b0;
    end else begin
      r_hdr_cnt      <= w_cnt_nxt;
      r_hdr_shd      <= w_shd_nxt;
      r_header_valid <= w_done;
      r_header_err   <= w_err;
      if (w_done) begin
        r_header_data <= w_shd_nxt;
      end
      if (w_done) begin
        r_first_pl <= 1'b1;
      end else if (r_state == DATA_ST && w_beat) begin
        r_first_pl <= 1'b0;
      end
    end
  end

  assign o_in_ready     = w_in_ready;
  assign o_header_data  = r_header_data;
  assign o_header_valid = r_header_valid;
  assign o_header_err   = r_header_err;

endmodule

// File: tb/tb_header_stripper.sv
// Directed bench for header_stripper: a 256-bit header instance and a 128-bit header instance share stimulus.
module tb_header_stripper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_sop, in_eop, out_ready;
  logic [127:0] in_data;
  logic [3:0]   in_empty;
  logic         sel;

  logic         d0_in_ready, d0_out_valid, d0_out_sop, d0_out_eop, d0_hv, d0_err;
  logic [127:0] d0_out_data;
  logic [3:0]   d0_out_empty;
  logic [255:0] d0_hdr;
  logic         d1_in_ready, d1_out_valid, d1_out_sop, d1_out_eop, d1_hv, d1_err;
  logic [127:0] d1_out_data;
  logic [3:0]   d1_out_empty;
  logic [127:0] d1_hdr;

  header_stripper #(.DATA_WIDTH(128), .HEADER_SIZE(256)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(d0_in_ready), .i_in_sop(in_sop), .i_in_eop(in_eop),
    .i_in_data(in_data), .i_in_empty(in_empty),
    .o_out_valid(d0_out_valid), .i_out_ready(out_ready), .o_out_sop(d0_out_sop), .o_out_eop(d0_out_eop),
    .o_out_data(d0_out_data), .o_out_empty(d0_out_empty),
    .o_header_data(d0_hdr), .o_header_valid(d0_hv), .o_header_err(d0_err)
  );

  header_stripper #(.DATA_WIDTH(128), .HEADER_SIZE(128)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(d1_in_ready), .i_in_sop(in_sop), .i_in_eop(in_eop),
    .i_in_data(in_data), .i_in_empty(in_empty),
    .o_out_valid(d1_out_valid), .i_out_ready(out_ready), .o_out_sop(d1_out_sop), .o_out_eop(d1_out_eop),
    .o_out_data(d1_out_data), .o_out_empty(d1_out_empty),
    .o_header_data(d1_hdr), .o_header_valid(d1_hv), .o_header_err(d1_err)
  );

  wire         w_in_ready  = sel ? d1_in_ready  : d0_in_ready;
  wire         w_out_valid = sel ? d1_out_valid : d0_out_valid;
  wire         w_out_sop   = sel ? d1_out_sop   : d0_out_sop;
  wire         w_out_eop   = sel ? d1_out_eop   : d0_out_eop;
  wire [127:0] w_out_data  = sel ? d1_out_data  : d0_out_data;
  wire [3:0]   w_out_empty = sel ? d1_out_empty : d0_out_empty;
  wire [255:0] w_hdr       = sel ? {128'b0, d1_hdr} : d0_hdr;
  wire         w_hv        = sel ? d1_hv  : d0_hv;
  wire         w_err       = sel ? d1_err : d0_err;

  localparam logic [127:0] H0 = 128'h1000_0000_0000_0000_0000_0000_0000_00A0;
  localparam logic [127:0] H1 = 128'h1100_0000_0000_0000_0000_0000_0000_00A1;
  localparam logic [127:0] A0 = 128'h2000_0000_0000_0000_0000_0000_0000_00B0;
  localparam logic [127:0] A1 = 128'h2100_0000_0000_0000_0000_0000_0000_00B1;
  localparam logic [127:0] G0 = 128'h3000_0000_0000_0000_0000_0000_0000_00C0;
  localparam logic [127:0] G1 = 128'h3100_0000_0000_0000_0000_0000_0000_00C1;
  localparam logic [127:0] B0 = 128'h4000_0000_0000_0000_0000_0000_0000_00D0;
  localparam logic [127:0] B1 = 128'h4100_0000_0000_0000_0000_0000_0000_00D1;
  localparam logic [127:0] C0 = 128'h5000_0000_0000_0000_0000_0000_0000_00E0;
  localparam logic [127:0] C1 = 128'h5100_0000_0000_0000_0000_0000_0000_00E1;
  localparam logic [127:0] D0 = 128'h6000_0000_0000_0000_0000_0000_0000_00F0;
  localparam logic [127:0] D1 = 128'h6100_0000_0000_0000_0000_0000_0000_00F1;
  localparam logic [127:0] R0 = 128'h7000_0000_0000_0000_0000_0000_0000_0070;
  localparam logic [127:0] R1 = 128'h7100_0000_0000_0000_0000_0000_0000_0071;
  localparam logic [127:0] P0 = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] P1 = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] Q0 = 128'hCAFE_F00D_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] XX = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

  typedef struct {
    logic [127:0] dat;
    logic         sop;
    logic         eop;
    logic [3:0]   emp;
  } beat_t;

  beat_t        q_out[$];
  logic [255:0] q_hdr[$];
  logic         rdy_q[$];
  int n_hv, n_err, n_both, n_stall, hv_cyc, acc_cyc, h1_cyc;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (w_out_valid && out_ready) q_out.push_back('{w_out_data, w_out_sop, w_out_eop, w_out_empty});
      if (w_hv) begin
        n_hv++;
        q_hdr.push_back(w_hdr);
        hv_cyc = cyc;
      end
      if (w_err) n_err++;
      if (w_hv && w_err) n_both++;
      if (in_valid && !w_in_ready) n_stall++;
    end
  end

  task automatic clr();
    q_out.delete();
    q_hdr.delete();
    n_hv = 0; n_err = 0; n_stall = 0;
  endtask

  task automatic send(input logic s, input logic e, input logic [127:0] d, input logic [3:0] em);
    bit done;
    int t;
    in_valid = 1'b1; in_sop = s; in_eop = e; in_data = d; in_empty = em;
    done = 1'b0;
    t = 0;
    while (!done && t < 50) begin
      out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      @(negedge clk);
      done = w_in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("accept", {255'b0, done}, 256'd1);
    acc_cyc = cyc;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input int i, input logic [127:0] d,
                            input logic s, input logic e, input logic [3:0] em);
    if (i >= q_out.size()) begin
      check_eq({tag, "_missing"}, 256'(q_out.size()), 256'(i + 1));
    end else begin
      check_eq({tag, "_dat"}, {128'b0, q_out[i].dat}, {128'b0, d});
      check_eq({tag, "_sop"}, {255'b0, q_out[i].sop}, {255'b0, s});
      check_eq({tag, "_eop"}, {255'b0, q_out[i].eop}, {255'b0, e});
      check_eq({tag, "_emp"}, {252'b0, q_out[i].emp}, {252'b0, em});
    end
  endtask

  task automatic check_hdr(input string tag, input int i, input logic [255:0] exp);
    if (i >= q_hdr.size()) check_eq({tag, "_missing"}, 256'(q_hdr.size()), 256'(i + 1));
    else check_eq(tag, q_hdr[i], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_data = '0; in_empty = '0; out_ready = 1'b1; sel = 1'b0;
    n_both = 0;
    clr();
    #3;
    check_eq("rst_in_ready", {255'b0, w_in_ready}, 256'd1);
    check_eq("rst_out_valid", {255'b0, w_out_valid}, 256'd0);
    check_eq("rst_hdr", w_hdr, 256'd0);
    check_eq("rst_hv", {255'b0, w_hv}, 256'd0);
    check_eq("rst_err", {255'b0, w_err}, 256'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // basic strip
    clr();
    send(1, 0, H0, 0); send(0, 0, H1, 0); h1_cyc = acc_cyc;
    send(0, 0, P0, 4'd5); send(0, 1, P1, 4'd3);
    idle(3);
    check_eq("t1_nbeats", 256'(q_out.size()), 256'd2);
    check_beat("t1_b0", 0, P0, 1, 0, 0);
    check_beat("t1_b1", 1, P1, 0, 1, 3);
    check_eq("t1_nhv", 256'(n_hv), 256'd1);
    check_hdr("t1_hdr", 0, {H0, H1});
    check_eq("t1_hv_cycle", 256'(hv_cyc), 256'(h1_cyc));
    check_eq("t1_nerr", 256'(n_err), 256'd0);

    // downstream backpressure; header beats must ignore it
    clr();
    rdy_q.push_back(0); send(1, 0, A0, 0);
    rdy_q.push_back(0); send(0, 0, A1, 0);
    rdy_q.push_back(1); rdy_q.push_back(0); rdy_q.push_back(0); rdy_q.push_back(1);
    send(0, 0, P0, 0); send(0, 1, P1, 4'd3);
    idle(3);
    check_eq("t2_nbeats", 256'(q_out.size()), 256'd2);
    check_eq("t2_stalls", 256'(n_stall), 256'd2);
    check_beat("t2_b0", 0, P0, 1, 0, 0);
    check_beat("t2_b1", 1, P1, 0, 1, 3);
    check_hdr("t2_hdr", 0, {A0, A1});

    // short packet
    clr();
    send(1, 0, G0, 0); send(0, 1, G1, 0);
    idle(3);
    check_eq("t3_nbeats", 256'(q_out.size()), 256'd0);
    check_eq("t3_nerr", 256'(n_err), 256'd1);
    check_eq("t3_nhv", 256'(n_hv), 256'd0);
    check_eq("t3_hdr_kept", w_hdr, {A0, A1});

    // garbage in idle, then good packet
    clr();
    send(0, 0, XX, 0); send(0, 1, XX, 2); send(0, 0, XX, 0);
    send(1, 0, B0, 0); send(0, 0, B1, 0); send(0, 0, P0, 0); send(0, 1, P1, 4'd3);
    idle(3);
    check_eq("t4_nbeats", 256'(q_out.size()), 256'd2);
    check_eq("t4_nerr", 256'(n_err), 256'd0);
    check_eq("t4_nhv", 256'(n_hv), 256'd1);
    check_hdr("t4_hdr", 0, {B0, B1});
    check_beat("t4_b0", 0, P0, 1, 0, 0);

    // back-to-back packets; sop inside payload forwarded as data
    clr();
    send(1, 0, C0, 0); send(0, 0, C1, 0); send(0, 0, P0, 0); send(1, 1, P1, 4'd3);
    send(1, 0, D0, 0); send(0, 0, D1, 0); send(0, 1, Q0, 4'd7);
    idle(3);
    check_eq("t5_nbeats", 256'(q_out.size()), 256'd3);
    check_beat("t5_b0", 0, P0, 1, 0, 0);
    check_beat("t5_b1", 1, P1, 0, 1, 3);
    check_beat("t5_b2", 2, Q0, 1, 1, 7);
    check_eq("t5_nhv", 256'(n_hv), 256'd2);
    check_hdr("t5_hdr0", 0, {C0, C1});
    check_hdr("t5_hdr1", 1, {D0, D1});
    check_eq("t5_nerr", 256'(n_err), 256'd0);

    // sop restart mid-header
    clr();
    send(1, 0, H0, 0); send(1, 0, R0, 0); send(0, 0, R1, 0); send(0, 1, P0, 0);
    idle(3);
    check_eq("t7_nerr", 256'(n_err), 256'd1);
    check_eq("t7_nhv", 256'(n_hv), 256'd1);
    check_hdr("t7_hdr", 0, {R0, R1});
    check_beat("t7_b0", 0, P0, 1, 1, 0);
    check_eq("no_hv_err_overlap", 256'(n_both), 256'd0);

    // single-beat header instance, with reset mid-payload
    sel = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    clr();
    send(1, 0, H0, 0); send(0, 1, P0, 4'd2);
    idle(3);
    check_eq("t6_nbeats", 256'(q_out.size()), 256'd1);
    check_beat("t6_b0", 0, P0, 1, 1, 2);
    check_hdr("t6_hdr", 0, {128'b0, H0});
    send(1, 0, A0, 0); send(0, 0, P0, 0);
    in_valid = 1'b1; in_data = P1; in_eop = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_out_valid", {255'b0, w_out_valid}, 256'd0);
    check_eq("t6_rst_out_data", {128'b0, w_out_data}, 256'd0);
    check_eq("t6_rst_in_ready", {255'b0, w_in_ready}, 256'd1);
    check_eq("t6_rst_hdr", w_hdr, 256'd0);
    check_eq("t6_rst_pulses", {254'b0, w_hv, w_err}, 256'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clr();
    send(1, 0, B0, 0); send(0, 1, Q0, 4'd1);
    idle(3);
    check_eq("t6_post_nbeats", 256'(q_out.size()), 256'd1);
    check_beat("t6_post_b0", 0, Q0, 1, 1, 1);
    check_hdr("t6_post_hdr", 0, {128'b0, B0});
    check_eq("t6_post_nerr", 256'(n_err), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
